// File: rtl/dm_wbuf_pkg.sv
// Shared constants and types for the data-memory posted write buffer.
// Module parameters default to the values below.
package dm_wbuf_pkg;

    localparam int unsigned DEF_DEPTH  = 4;
    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned PTR_W      = $clog2(DEF_DEPTH);

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
        logic                  valid;
    } entry_t;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dm_wbuf_match.sv
// Youngest-match search over the buffered stores for load forwarding.
// Entries are scanned oldest to youngest so the last hit seen wins.
module dm_wbuf_match
    import dm_wbuf_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned PW     = ptr_width(DEF_DEPTH)
) (
    input  logic [ADDR_W-1:0] ent_addr [DEPTH],
    input  logic [DATA_W-1:0] ent_data [DEPTH],
    input  logic [DEPTH-1:0]  ent_valid,
    input  logic [PW-1:0]     tail,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);

    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        // offset DEPTH wraps to tail itself, which is the oldest slot when full
        for (int unsigned i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] idx;
            idx = tail - PW'(DEPTH - i);
            if (ent_valid[idx] && (ent_addr[idx] == cpu_addr)) begin
                hit      = 1'b1;
                hit_data = ent_data[idx];
            end
        end
    end

endmodule

// File: rtl/dm_wbuf.sv
// Posted write buffer between the core data-memory port and DM.
// Stores retire into a FIFO that drains whenever the core is not loading.
module dm_wbuf
    import dm_wbuf_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_wen,
    input  logic              cpu_ren,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              flush,
    output logic              empty,
    output logic              full,
    output logic              err
);

    localparam int unsigned PW = ptr_width(DEPTH);

    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0]  ent_valid;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW:0]       count;
    logic              err_q;

    logic cpu_ren_eff;
    logic push;
    logic pop;
    logic hit;
    logic [DATA_W-1:0] hit_data;

    // drain is continuous; the hint input carries no function
    logic unused_flush;
    assign unused_flush = flush;

    assign cpu_ren_eff = cpu_ren & ~cpu_wen;
    assign push        = cpu_wen;
    assign pop         = (count != '0) & ~cpu_ren_eff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            err_q     <= 1'b0;
        end else begin
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PW'(1);
            end
            // placed after the pop clear so a full push+pop keeps the slot valid
            if (push) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (cpu_wen && cpu_ren) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= cpu_addr;
            ent_data[tail] <= cpu_wdata;
        end
    end

    dm_wbuf_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .PW     (PW)
    ) u_match (
        .ent_addr  (ent_addr),
        .ent_data  (ent_data),
        .ent_valid (ent_valid),
        .tail      (tail),
        .cpu_addr  (cpu_addr),
        .hit       (hit),
        .hit_data  (hit_data)
    );

    assign cpu_rdata = hit ? hit_data : mem_rdata;
    assign mem_wen   = pop;
    assign mem_addr  = pop ? ent_addr[head] : cpu_addr;
    assign mem_wdata = ent_data[head];

    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));
    assign err   = err_q;

    a_count_bound : assert property (@(posedge clk) disable iff (!rst)
        count <= (PW+1)'(DEPTH));
    a_no_pop_on_load : assert property (@(posedge clk) disable iff (!rst)
        cpu_ren_eff |-> !mem_wen);

endmodule

// File: tb/tb_dm_wbuf.sv
// Scoreboard bench for dm_wbuf: a queue-based reference model predicts each
// cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_dm_wbuf;
    import dm_wbuf_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic        cpu_wen = 1'b0;
    logic        cpu_ren = 1'b0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic [15:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        flush = 1'b0;
    logic        empty;
    logic        full;
    logic        err;

    always #5 clk = ~clk;

    dm_wbuf #(.DEPTH(DEPTH), .ADDR_W(16), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wen   (cpu_wen),
        .cpu_ren   (cpu_ren),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .flush     (flush),
        .empty     (empty),
        .full      (full),
        .err       (err)
    );

    // data memory seen by the DUT
    logic [31:0] dm [256];
    assign mem_rdata = dm[mem_addr[7:0]];
    always @(posedge clk) if (mem_wen) dm[mem_addr[7:0]] <= mem_wdata;

    // reference model state
    entry_t      mq[$];
    logic [31:0] ref_dm [256];
    bit          m_err;

    typedef struct {
        bit          wen;
        logic [15:0] addr;
        logic [31:0] data;
        bit          chk_rd;
        logic [31:0] rdata;
        bit          empty;
        bit          full;
        bit          err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("empty", 32'(empty), 32'(e.empty));
            chk("full", 32'(full), 32'(e.full));
            chk("err", 32'(err), 32'(e.err));
            chk("mem_wen", 32'(mem_wen), 32'(e.wen));
            chk("mem_addr", 32'(mem_addr), 32'(e.addr));
            if (e.wen) chk("mem_wdata", mem_wdata, e.data);
            if (e.chk_rd) chk("cpu_rdata", cpu_rdata, e.rdata);
        end
    end

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            @(posedge clk); #1;
            rst = 1'b0; cpu_wen = 1'b0; cpu_ren = 1'b0;
            e = '{wen: 1'b0, addr: cpu_addr, data: '0, chk_rd: 1'b0, rdata: '0,
                  empty: 1'b1, full: 1'b0, err: 1'b0};
            sb.push_back(e);
            mq.delete();
            m_err = 1'b0;
        end
    endtask

    task automatic step(input bit w, input bit r, input logic [15:0] a, input logic [31:0] d);
        exp_t e;
        bit   ren_eff, pop, found;
        entry_t ne;
        @(posedge clk); #1;
        rst = 1'b1; cpu_wen = w; cpu_ren = r; cpu_addr = a; cpu_wdata = d;
        ren_eff = r && !w;
        pop     = (mq.size() != 0) && !ren_eff;
        e.empty = (mq.size() == 0);
        e.full  = (mq.size() == DEPTH);
        e.err   = m_err;
        e.wen   = pop;
        e.addr  = pop ? mq[0].addr : a;
        e.data  = pop ? mq[0].data : '0;
        e.chk_rd = ren_eff;
        found   = 1'b0;
        e.rdata = ref_dm[a[7:0]];
        for (int k = mq.size() - 1; k >= 0 && !found; k--) begin
            if (mq[k].addr == a) begin
                e.rdata = mq[k].data;
                found   = 1'b1;
            end
        end
        sb.push_back(e);
        if (pop) begin
            ref_dm[mq[0].addr[7:0]] = mq[0].data;
            void'(mq.pop_front());
        end
        if (w) begin
            ne.addr = a; ne.data = d; ne.valid = 1'b1;
            mq.push_back(ne);
        end
        if (w && r) m_err = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'(i), '0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            dm[i]     = 32'hA5A50000 + 32'(i);
            ref_dm[i] = 32'hA5A50000 + 32'(i);
        end
        for (int i = 0; i < 4; i++) begin
            dm[i]     = 32'h1000 * 32'(i + 1);
            ref_dm[i] = 32'h1000 * 32'(i + 1);
        end
        m_err = 1'b0;

        reset_cycles(2);
        idle(2);

        // store then drain
        step(1'b1, 1'b0, 16'd5, 32'hDEADBEEF);
        idle(3);

        // forwarding from the buffer and miss to DM
        step(1'b1, 1'b0, 16'd8, 32'h11);
        step(1'b1, 1'b0, 16'd8, 32'h22);
        step(1'b0, 1'b1, 16'd8, '0);
        step(1'b0, 1'b1, 16'd9, '0);
        idle(2);

        // stores followed by a run of loads
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'(i), 32'hC0DE0000 + 32'(i));
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'(i % 4), '0);
        idle(4);

        // interleaved stores and loads, then one more store
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 16'(i), 32'hF00D0000 + 32'(i));
            step(1'b0, 1'b1, 16'(i), '0);
        end
        step(1'b1, 1'b0, 16'd12, 32'h12121212);
        idle(3);

        // randomized traffic without protocol errors
        for (int i = 0; i < 400; i++) begin
            bit w, r;
            w = ($urandom_range(0, 99) < 45);
            r = !w && ($urandom_range(0, 99) < 50);
            step(w, r, 16'($urandom_range(0, 15)), $urandom);
        end
        idle(3);

        // protocol error is sticky
        step(1'b1, 1'b1, 16'd20, 32'hBAD0BAD0);
        idle(2);
        step(1'b0, 1'b1, 16'd20, '0);

        // reset with a store pending
        step(1'b1, 1'b0, 16'd30, 32'h30303030);
        step(1'b0, 1'b1, 16'd31, '0);
        reset_cycles(1);
        idle(3);

        // randomized traffic including protocol errors and resets
        for (int i = 0; i < 200; i++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 2) reset_cycles(1);
            else step(sel < 45, (sel >= 40) && (sel < 80), 16'($urandom_range(0, 15)), $urandom);
        end
        idle(4);

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        for (int i = 0; i < 256; i++) chk("dm_contents", dm[i], ref_dm[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
